// File: rtl/preg_pkg.sv
// Shared defaults and state encoding for the pointer-register write scheduler.
package preg_pkg;

   localparam int NPREG_DEF = 64;   // pointer-register entries cleared by a sweep
   localparam int PW_DEF    = 6;    // pointer-register address width
   localparam int LBW_DEF   = 12;   // label-ID width
   localparam int OFW_DEF   = 16;   // offset width

   // INIT clears every entry; RUN forwards requester writes
   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. req[0]/gnt[0] is requester A, req[1]/gnt[1]
// is requester B. The last-grant flag comes out of reset pointing at B so
// that A wins the first tie.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic last_b_q;
   logic last_b_d;

   // Lone requester wins; on a tie the one not served most recently wins
   always_comb begin
      gnt = 2'b00;
      if (req[0] && (!req[1] || last_b_q)) begin
         gnt = 2'b01;
      end else if (req[1]) begin
         gnt = 2'b10;
      end
   end

   // Remember who was served, only when the grant is actually taken
   always_comb begin
      last_b_d = last_b_q;
      if (advance && gnt[1]) begin
         last_b_d = 1'b1;
      end else if (advance && gnt[0]) begin
         last_b_d = 1'b0;
      end
   end

   // Last-grant flag register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_b_q <= 1'b1;
      end else begin
         last_b_q <= last_b_d;
      end
   end

endmodule

// File: rtl/preg_wr_sched.sv
// Pointer-register write scheduler: after reset (or on init_req) it sweeps
// zeros into every entry, then merges two requester streams onto a single
// registered write port with round-robin arbitration.
module preg_wr_sched
   import preg_pkg::*;
#(
   parameter int NPREG = NPREG_DEF,
   parameter int PW    = PW_DEF,
   parameter int LBW   = LBW_DEF,
   parameter int OFW   = OFW_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           init_req,
   input  logic           a_valid,
   output logic           a_ready,
   input  logic [PW-1:0]  a_p,
   input  logic [LBW-1:0] a_lbid,
   input  logic [OFW-1:0] a_ofs,
   input  logic           b_valid,
   output logic           b_ready,
   input  logic [PW-1:0]  b_p,
   input  logic [LBW-1:0] b_lbid,
   input  logic [OFW-1:0] b_ofs,
   output logic           we,
   output logic [PW-1:0]  pw,
   output logic [LBW-1:0] lbidw,
   output logic [OFW-1:0] ofsw,
   output logic           busy
);

   localparam logic [PW-1:0] LAST_IDX = PW'(NPREG - 1);

   state_e         state_q, state_d;
   logic [PW-1:0]  cnt_q, cnt_d;
   logic           we_q, we_d;
   logic [PW-1:0]  pw_q, pw_d;
   logic [LBW-1:0] lbidw_q, lbidw_d;
   logic [OFW-1:0] ofsw_q, ofsw_d;

   logic           run_ok;
   logic [1:0]     req;
   logic [1:0]     gnt;

   // Grants are only offered in RUN and are withheld while a re-init is requested
   assign run_ok = (state_q == ST_RUN) && !init_req;
   assign req    = {b_valid, a_valid} & {2{run_ok}};

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .advance (run_ok),
      .gnt     (gnt)
   );

   assign a_ready = gnt[0];
   assign b_ready = gnt[1];
   assign busy    = (state_q == ST_INIT);
   assign we      = we_q;
   assign pw      = pw_q;
   assign lbidw   = lbidw_q;
   assign ofsw    = ofsw_q;

   // Next state: sweep writes in INIT, granted payload (or hold) in RUN
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      pw_d    = pw_q;
      lbidw_d = lbidw_q;
      ofsw_d  = ofsw_q;
      if (state_q == ST_INIT) begin
         we_d    = 1'b1;
         pw_d    = cnt_q;
         lbidw_d = '0;
         ofsw_d  = '0;
         if (cnt_q == LAST_IDX) begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (init_req) begin
         state_d = ST_INIT;
         cnt_d   = '0;
      end else if (gnt[0]) begin
         we_d    = 1'b1;
         pw_d    = a_p;
         lbidw_d = a_lbid;
         ofsw_d  = a_ofs;
      end else if (gnt[1]) begin
         we_d    = 1'b1;
         pw_d    = b_p;
         lbidw_d = b_lbid;
         ofsw_d  = b_ofs;
      end
   end

   // State, sweep counter and registered write port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         pw_q    <= '0;
         lbidw_q <= '0;
         ofsw_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         pw_q    <= pw_d;
         lbidw_q <= lbidw_d;
         ofsw_q  <= ofsw_d;
      end
   end

endmodule

// File: tb/tb_preg_wr_sched.sv
// Scoreboard bench for preg_wr_sched: a reference model predicts grants and
// the next write-port value each cycle; predictions are queued and popped
// when the DUT's registered write port updates.
module tb_preg_wr_sched;

   localparam int NP = 64;
   localparam int P  = 6;
   localparam int L  = 12;
   localparam int O  = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         init_req;
   logic         a_valid, b_valid;
   logic         a_ready, b_ready;
   logic [P-1:0] a_p, b_p;
   logic [L-1:0] a_lbid, b_lbid;
   logic [O-1:0] a_ofs, b_ofs;
   logic         we;
   logic [P-1:0] pw;
   logic [L-1:0] lbidw;
   logic [O-1:0] ofsw;
   logic         busy;

   typedef struct packed {
      logic         we;
      logic [P-1:0] pw;
      logic [L-1:0] lb;
      logic [O-1:0] of;
   } wr_t;

   wr_t exp_q[$];
   int  n_chk = 0;
   int  n_err = 0;

   // reference model state
   logic         m_run;
   int           m_cnt;
   logic         m_last_b;
   logic [P-1:0] m_pw;
   logic [L-1:0] m_lb;
   logic [O-1:0] m_of;

   always #5 clk = ~clk;

   preg_wr_sched #(.NPREG(NP), .PW(P), .LBW(L), .OFW(O)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .init_req (init_req),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .a_p      (a_p),
      .a_lbid   (a_lbid),
      .a_ofs    (a_ofs),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .b_p      (b_p),
      .b_lbid   (b_lbid),
      .b_ofs    (b_ofs),
      .we       (we),
      .pw       (pw),
      .lbidw    (lbidw),
      .ofsw     (ofsw),
      .busy     (busy)
   );

   // requesters must hold valid and payload until accepted
   a_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (a_valid && !a_ready) |=> (a_valid && $stable({a_p, a_lbid, a_ofs})));
   b_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (b_valid && !b_ready) |=> (b_valid && $stable({b_p, b_lbid, b_ofs})));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_run    = 1'b0;
      m_cnt    = 0;
      m_last_b = 1'b1;
      m_pw     = '0;
      m_lb     = '0;
      m_of     = '0;
      exp_q.delete();
   endtask

   task automatic check_reset_values();
      check("rst_we", we, 1'b0);
      check("rst_pw", pw, 0);
      check("rst_lbidw", lbidw, 0);
      check("rst_ofsw", ofsw, 0);
      check("rst_busy", busy, 1'b1);
      check("rst_a_ready", a_ready, 1'b0);
      check("rst_b_ready", b_ready, 1'b0);
   endtask

   // One clock cycle: drive at the falling edge, check grants, predict the
   // write, then compare the write port at the next falling edge.
   task automatic step(input logic av, input logic [P-1:0] ap, input logic [L-1:0] al,
                       input logic [O-1:0] ao, input logic bv, input logic [P-1:0] bp,
                       input logic [L-1:0] bl, input logic [O-1:0] bo, input logic ir,
                       output logic ga, output logic gb);
      wr_t ex;
      wr_t got;
      check("busy", busy, !m_run);
      a_valid = av; a_p = ap; a_lbid = al; a_ofs = ao;
      b_valid = bv; b_p = bp; b_lbid = bl; b_ofs = bo;
      init_req = ir;
      #1;
      ga = 1'b0;
      gb = 1'b0;
      ex.we = 1'b0; ex.pw = m_pw; ex.lb = m_lb; ex.of = m_of;
      if (!m_run) begin
         ex.we = 1'b1; ex.pw = P'(m_cnt); ex.lb = '0; ex.of = '0;
         if (m_cnt == NP - 1) begin
            m_run = 1'b1;
            m_cnt = 0;
         end else begin
            m_cnt++;
         end
      end else if (ir) begin
         m_run = 1'b0;
         m_cnt = 0;
      end else begin
         ga = av && (!bv || m_last_b);
         gb = bv && !ga;
         if (ga) begin
            ex.we = 1'b1; ex.pw = ap; ex.lb = al; ex.of = ao;
            m_last_b = 1'b0;
            $display("xfer A p=%0d lbid=%h ofs=%h", ap, al, ao);
         end else if (gb) begin
            ex.we = 1'b1; ex.pw = bp; ex.lb = bl; ex.of = bo;
            m_last_b = 1'b1;
            $display("xfer B p=%0d lbid=%h ofs=%h", bp, bl, bo);
         end
      end
      check("a_ready", a_ready, ga);
      check("b_ready", b_ready, gb);
      m_pw = ex.pw; m_lb = ex.lb; m_of = ex.of;
      exp_q.push_back(ex);
      @(negedge clk);
      got = exp_q.pop_front();
      check("we", we, got.we);
      check("pw", pw, got.pw);
      check("lbidw", lbidw, got.lb);
      check("ofsw", ofsw, got.of);
   endtask

   task automatic idle(input logic ir);
      logic ga, gb;
      step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, ir, ga, gb);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic         ga, gb;
      logic         pa, pb;
      logic [P-1:0] rap, rbp;
      logic [L-1:0] ral, rbl;
      logic [O-1:0] rao, rbo;
      logic         rir;

      // reset with both requesters asserting valid: no grants allowed
      rst_n = 1'b0;
      init_req = 1'b0;
      a_valid = 1'b1; a_p = '0; a_lbid = '0; a_ofs = '0;
      b_valid = 1'b1; b_p = '0; b_lbid = '0; b_ofs = '0;
      model_reset();
      #3;
      check_reset_values();
      @(negedge clk);
      @(negedge clk);
      a_valid = 1'b0;
      b_valid = 1'b0;
      rst_n = 1'b1;

      // first sweep; an init_req mid-sweep must be ignored
      for (int i = 0; i < NP; i++) idle(i == 10);
      idle(1'b0);   // RUN, no transfer: port holds

      // A alone
      step(1'b1, 6'd5, 12'h123, 16'h00FF, 1'b0, '0, '0, '0, 1'b0, ga, gb);
      // B alone so the next tie goes to A
      step(1'b0, '0, '0, '0, 1'b1, 6'd7, 12'h0AA, 16'h1111, 1'b0, ga, gb);
      // four back-to-back transfers A,B,A,B with same-address ordering
      step(1'b1, 6'd9, 12'h001, 16'hA001, 1'b1, 6'd9, 12'h002, 16'hB002, 1'b0, ga, gb);
      step(1'b1, 6'd9, 12'h003, 16'hA003, 1'b1, 6'd9, 12'h002, 16'hB002, 1'b0, ga, gb);
      step(1'b1, 6'd9, 12'h003, 16'hA003, 1'b1, 6'd9, 12'h004, 16'hB004, 1'b0, ga, gb);
      step(1'b0, '0, '0, '0, 1'b1, 6'd9, 12'h004, 16'hB004, 1'b0, ga, gb);
      idle(1'b0);

      // B waiting through a re-init sweep, granted in the first RUN cycle
      for (int i = 0; i < NP + 2; i++) begin
         step(1'b0, '0, '0, '0, 1'b1, 6'd33, 12'h5A5, 16'hC0DE, (i == 0), ga, gb);
         if (gb) break;
      end
      idle(1'b0);

      // random traffic with occasional re-init
      pa = 1'b0; pb = 1'b0;
      rap = '0; ral = '0; rao = '0; rbp = '0; rbl = '0; rbo = '0;
      for (int c = 0; c < 300; c++) begin
         if (!pa && $urandom_range(0, 2) != 0) begin
            pa = 1'b1; rap = P'($urandom); ral = L'($urandom); rao = O'($urandom);
         end
         if (!pb && $urandom_range(0, 2) != 0) begin
            pb = 1'b1; rbp = P'($urandom); rbl = L'($urandom); rbo = O'($urandom);
         end
         rir = ($urandom_range(0, 99) == 0);
         step(pa, rap, ral, rao, pb, rbp, rbl, rbo, rir, ga, gb);
         if (ga) pa = 1'b0;
         if (gb) pb = 1'b0;
      end
      for (int c = 0; c < 200 && (pa || pb); c++) begin
         step(pa, rap, ral, rao, pb, rbp, rbl, rbo, 1'b0, ga, gb);
         if (ga) pa = 1'b0;
         if (gb) pb = 1'b0;
      end
      check("drained", {31'd0, pa | pb}, 0);
      idle(1'b0);

      // fresh reset, then abort the sweep at count 30 with an async reset
      #2;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) idle(1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NP; i++) idle(1'b0);
      step(1'b1, 6'd63, 12'hFFF, 16'hFFFF, 1'b1, 6'd0, 12'h000, 16'h0000, 1'b0, ga, gb);
      step(1'b0, '0, '0, '0, 1'b1, 6'd0, 12'h000, 16'h0000, 1'b0, ga, gb);
      idle(1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/preg_wr_sched.md
PREG_WR_SCHED -- requirements
Module: preg_wr_sched

Interface
REQ-001 The block SHALL have parameter NPREG, default 64: number of pointer-register entries swept at init.
REQ-002 The block SHALL have parameter PW, default 6: pointer-register address width.
REQ-003 The block SHALL have parameter LBW, default 12: label-ID width.
REQ-004 The block SHALL have parameter OFW, default 16: offset width.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-006 The block SHALL have port init_req  in  1: requests a re-clear sweep of all entries.
REQ-007 The block SHALL have ports a_valid  in  1, a_ready  out  1, a_p  in  PW, a_lbid  in  LBW, a_ofs  in  OFW: requester A write request.
REQ-008 The block SHALL have ports b_valid  in  1, b_ready  out  1, b_p  in  PW, b_lbid  in  LBW, b_ofs  in  OFW: requester B write request.
REQ-009 The block SHALL have ports we  out  1, pw  out  PW, lbidw  out  LBW, ofsw  out  OFW: registered write port to the pointer-register file.
REQ-010 The block SHALL have port busy  out  1: high while an init sweep is running.

Function
REQ-011 The block SHALL have two states, INIT and RUN, and SHALL enter INIT with sweep counter = 0 on reset.
REQ-012 In INIT, each cycle the block SHALL register we=1, pw=counter, lbidw=0 and ofsw=0, then increment the counter.
REQ-013 After registering the write for counter = NPREG-1, the block SHALL go to RUN; a full sweep SHALL take exactly NPREG cycles.
REQ-014 In INIT, a_ready and b_ready SHALL be 0 and busy SHALL be 1; in RUN, busy SHALL be 0.
REQ-015 In RUN, a_ready and b_ready SHALL be combinational grants; at most one of them SHALL be 1 per cycle, and a grant SHALL only go to a requester whose valid is 1.
REQ-016 When only one requester is valid, it SHALL be granted.
REQ-017 When both are valid, the requester not granted most recently SHALL be granted (round-robin); the last-grant flag SHALL reset to B so that A wins the first tie.
REQ-018 A transfer SHALL occur on a rising edge with valid&ready=1; its p/lbid/ofs SHALL appear on pw/lbidw/ofsw with we=1 in the following cycle (1-cycle latency).
REQ-019 A cycle with no transfer in RUN SHALL register we=0; pw/lbidw/ofsw SHALL then hold their previous values.
REQ-020 Sustained throughput SHALL be one write per cycle; two requests to the same address SHALL be written in grant order.
REQ-021 Requesters SHALL hold valid and payload stable until ready; the bench SHALL assert this rule.
REQ-022 init_req=1 in RUN SHALL force a_ready=b_ready=0 in that cycle and move to INIT with counter=0 at the next edge.
REQ-023 init_req during INIT SHALL be ignored; the sweep in progress SHALL not restart.
REQ-024 The round-robin flag SHALL be unchanged by an init sweep.

Reset
REQ-025 While rst_n=0, outputs SHALL be: we=0, pw=0, lbidw=0, ofsw=0, busy=1, a_ready=0, b_ready=0.
REQ-026 Assertion of rst_n=0 mid-sweep or mid-stream SHALL abort immediately; no partial write SHALL be issued.
REQ-027 The first sweep write (pw=0) SHALL appear in the cycle after the first rising edge following rst_n release.

Structure
REQ-028 Package preg_pkg SHALL hold PW, LBW, OFW, NPREG defaults and the INIT/RUN state encoding.
REQ-029 The 2-way round-robin grant logic SHALL be a sub-module named rr_arb2 (inputs req[1:0], advance; outputs gnt[1:0]).

Verification
REQ-030 Release reset, idle requesters -> we=1 for 64 consecutive cycles, pw=0..63, lbidw=0, ofsw=0; then busy=0.
REQ-031 RUN, A only: a_p=5, a_lbid=0x123, a_ofs=0x00FF -> next cycle we=1, pw=5, lbidw=0x123, ofsw=0x00FF.
REQ-032 RUN, A and B both valid for 4 transfers -> grant order A,B,A,B; 4 back-to-back write cycles.
REQ-033 RUN, B valid with init_req=1 -> b_ready=0 that cycle; a 64-cycle sweep follows; B is granted in the first RUN cycle.
REQ-034 rst_n pulsed low at sweep count 30 -> outputs go to reset values immediately; the sweep restarts at pw=0 after release.
